// File: rtl/sn74hc165_reader.sv
// sn74hc165_reader
//
// Periodically scans a daisy chain of SN74HC165 parallel-in/serial-out shift
// registers. Each scan does three things in order:
//    1. Pulses SH/LD low to latch the parallel inputs.
//    2. Clocks the chain to read all BITS bits out through QH.
//    3. Writes the assembled word to one fixed BRAM address and publishes it
//       on sample_data.
//
// Ports
//    clk          system clock, rising edge
//    rst          synchronous active-high reset
//    enable       level, 1 = keep scanning
//    sr_qh        serial data from QH of the device nearest the reader
//    sr_clk       shift clock to all devices
//    sr_load_n    SH/LD to all devices, 0 = parallel load
//    port_c_addr  BRAM write address
//    port_c_din   BRAM write data (sample zero-extended)
//    port_c_we    BRAM write enable, one cycle per scan
//    sample_data  last completed sample
//    sample_valid one-cycle pulse when sample_data updates
//    busy         1 whenever the FSM is not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | outputs quiet, waits for enable
// LOAD       | SH/LD held low for CLK_DIV cycles
// SHIFT_LOW  | sr_clk low for CLK_DIV cycles, QH sampled on the last one
// SHIFT_HIGH | sr_clk high for CLK_DIV cycles (rising edge shifts chain)
// WRITE      | single cycle: BRAM write + sample_valid
// GAP        | SCAN_GAP idle cycles before returning to IDLE

module sn74hc165_reader #(
   parameter int NUM_CHIPS = 1,
   parameter int CLK_DIV   = 4,
   parameter int SCAN_GAP  = 0,
   parameter int ITEM_SIZE = 64,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       sr_qh,
   output logic                       sr_clk,
   output logic                       sr_load_n,
   output logic [$clog2(DEPTH):0]     port_c_addr,
   output logic [ITEM_SIZE-1:0]       port_c_din,
   output logic                       port_c_we,
   output logic [8*NUM_CHIPS-1:0]     sample_data,
   output logic                       sample_valid,
   output logic                       busy
);

   localparam int BITS = 8 * NUM_CHIPS;
   localparam int AW   = $clog2(DEPTH) + 1;
   localparam int CW   = 8;
   localparam int BW   = $clog2(BITS) + 1;
   localparam int GW   = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      SHIFT_LOW  = 3'd2,
      SHIFT_HIGH = 3'd3,
      WRITE      = 3'd4,
      GAP        = 3'd5
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        div_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [GW-1:0]        gap_q;
   logic [BITS-1:0]      data_q;
   logic [BITS-1:0]      data_d;
   logic                 sr_clk_q;
   logic                 sr_load_n_q;
   logic [AW-1:0]        addr_q;
   logic [ITEM_SIZE-1:0] din_q;
   logic                 we_q;
   logic [BITS-1:0]      sample_q;
   logic                 valid_q;
   logic                 busy_q;

   // Shift register contents after taking the current QH bit; MSB-first so
   // the first bit out (H of the nearest device) ends up in bit BITS-1.
   always_comb begin
      data_d = {data_q[BITS-2:0], sr_qh};
   end

   // Each timed state reloads div_q with CLK_DIV-1 and leaves when it hits 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         div_q       <= '0;
         bit_cnt_q   <= '0;
         gap_q       <= '0;
         data_q      <= '0;
         sr_clk_q    <= 1'b0;
         sr_load_n_q <= 1'b1;
         addr_q      <= '0;
         din_q       <= '0;
         we_q        <= 1'b0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         we_q    <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q     <= LOAD;
                  sr_load_n_q <= 1'b0;
                  sr_clk_q    <= 1'b0;
                  div_q       <= CW'(CLK_DIV - 1);
                  bit_cnt_q   <= '0;
                  busy_q      <= 1'b1;
               end
            end
            LOAD: begin
               if (div_q == '0) begin
                  state_q     <= SHIFT_LOW;
                  sr_load_n_q <= 1'b1;
                  div_q       <= CW'(CLK_DIV - 1);
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            SHIFT_LOW: begin
               if (div_q == '0) begin
                  data_q    <= data_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BW'(BITS - 1)) begin
                     // Last bit: the WRITE outputs appear together next cycle.
                     state_q  <= WRITE;
                     we_q     <= 1'b1;
                     addr_q   <= AW'(BASE_ADDR);
                     din_q    <= ITEM_SIZE'(data_d);
                     sample_q <= data_d;
                     valid_q  <= 1'b1;
                  end else begin
                     state_q  <= SHIFT_HIGH;
                     sr_clk_q <= 1'b1;
                     div_q    <= CW'(CLK_DIV - 1);
                  end
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            SHIFT_HIGH: begin
               if (div_q == '0) begin
                  state_q  <= SHIFT_LOW;
                  sr_clk_q <= 1'b0;
                  div_q    <= CW'(CLK_DIV - 1);
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            WRITE: begin
               bit_cnt_q <= '0;
               if (SCAN_GAP == 0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= GAP;
                  gap_q   <= GW'(SCAN_GAP - 1);
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               sr_clk_q    <= 1'b0;
               sr_load_n_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign sr_clk       = sr_clk_q;
   assign sr_load_n    = sr_load_n_q;
   assign port_c_addr  = addr_q;
   assign port_c_din   = din_q;
   assign port_c_we    = we_q;
   assign sample_data  = sample_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sn74hc165_reader.sv
// Bench for sn74hc165_reader. Two instances run side by side:
//    A: one chip, CLK_DIV=2, no scan gap
//    B: two chips, CLK_DIV=1, SCAN_GAP=5, 32-bit items, small BRAM
// Each instance drives a behavioural chain of SN74HC165 devices. Expected
// samples are the parallel words presented to that chain, and expected timing
// comes from closed-form scan-length formulas.

module tb_sn74hc165_reader;

   localparam int BITS_A = 8;
   localparam int DIV_A  = 2;
   localparam int BASE_A = 3;
   localparam int GAP_A  = 0;
   localparam int BITS_B = 16;
   localparam int DIV_B  = 1;
   localparam int BASE_B = 9;
   localparam int GAP_B  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, en_a, qh_a, srclk_a, loadn_a, we_a, valid_a, busy_a;
   logic [10:0] addr_a;
   logic [63:0] din_a;
   logic [7:0]  sample_a;
   logic        rst_b, en_b, qh_b, srclk_b, loadn_b, we_b, valid_b, busy_b;
   logic [4:0]  addr_b;
   logic [31:0] din_b;
   logic [15:0] sample_b;

   sn74hc165_reader #(.NUM_CHIPS(1), .CLK_DIV(DIV_A), .SCAN_GAP(GAP_A),
                      .ITEM_SIZE(64), .DEPTH(1024), .BASE_ADDR(BASE_A)) u_dut_a (
      .clk(clk), .rst(rst_a), .enable(en_a), .sr_qh(qh_a),
      .sr_clk(srclk_a), .sr_load_n(loadn_a), .port_c_addr(addr_a),
      .port_c_din(din_a), .port_c_we(we_a), .sample_data(sample_a),
      .sample_valid(valid_a), .busy(busy_a));

   sn74hc165_reader #(.NUM_CHIPS(2), .CLK_DIV(DIV_B), .SCAN_GAP(GAP_B),
                      .ITEM_SIZE(32), .DEPTH(16), .BASE_ADDR(BASE_B)) u_dut_b (
      .clk(clk), .rst(rst_b), .enable(en_b), .sr_qh(qh_b),
      .sr_clk(srclk_b), .sr_load_n(loadn_b), .port_c_addr(addr_b),
      .port_c_din(din_b), .port_c_we(we_b), .sample_data(sample_b),
      .sample_valid(valid_b), .busy(busy_b));

   // Device chains: async parallel load while SH/LD is low, shift on a rising
   // CLK edge. The nearest device's H bit sits at the chain MSB and drives QH.
   logic [7:0]  par_a = '0, chain_a = '0;
   logic [15:0] par_b = '0, chain_b = '0;

   always @(posedge srclk_a or negedge loadn_a)
      if (!loadn_a) chain_a <= par_a;
      else          chain_a <= {chain_a[6:0], 1'b0};
   always @(posedge srclk_b or negedge loadn_b)
      if (!loadn_b) chain_b <= par_b;
      else          chain_b <= {chain_b[14:0], 1'b0};
   assign qh_a = chain_a[7];
   assign qh_b = chain_b[15];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor: runs 1 ns after each edge and records per-instance scan events.
   logic        srclk_m[2], loadn_m[2], we_m[2], valid_m[2];
   logic [63:0] din_m[2], addr_m[2], sample_m[2];
   assign srclk_m[0] = srclk_a;   assign srclk_m[1] = srclk_b;
   assign loadn_m[0] = loadn_a;   assign loadn_m[1] = loadn_b;
   assign we_m[0]    = we_a;      assign we_m[1]    = we_b;
   assign valid_m[0] = valid_a;   assign valid_m[1] = valid_b;
   assign din_m[0]   = 64'(din_a);    assign din_m[1]    = 64'(din_b);
   assign addr_m[0]  = 64'(addr_a);   assign addr_m[1]   = 64'(addr_b);
   assign sample_m[0] = 64'(sample_a); assign sample_m[1] = 64'(sample_b);

   int          cyc = 0;
   int          edges[2], load_len[2], load_cyc[2], interval[2], load_cnt[2], we_cnt[2];
   logic        prev_clk[2], prev_ld[2];
   logic [63:0] w_din[2], w_addr[2], w_sample[2];
   int          w_edges[2], w_len[2], w_lat[2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         edges[d] = 0; load_len[d] = 0; load_cyc[d] = 0; interval[d] = 0;
         load_cnt[d] = 0; we_cnt[d] = 0; prev_clk[d] = 1'b0; prev_ld[d] = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (loadn_m[d] === 1'b0 && prev_ld[d] === 1'b1) begin
            interval[d] = cyc - load_cyc[d];
            load_cyc[d] = cyc;
            load_cnt[d]++;
            edges[d]    = 0;
            load_len[d] = 0;
         end
         if (loadn_m[d] === 1'b0) load_len[d]++;
         if (srclk_m[d] === 1'b1 && prev_clk[d] === 1'b0) edges[d]++;
         if (we_m[d] === 1'b1 || valid_m[d] === 1'b1)
            check("valid_with_we", 64'(valid_m[d]), 64'(we_m[d]));
         if (we_m[d] === 1'b1) begin
            w_din[d]    = din_m[d];
            w_addr[d]   = addr_m[d];
            w_sample[d] = sample_m[d];
            w_edges[d]  = edges[d];
            w_len[d]    = load_len[d];
            w_lat[d]    = cyc - load_cyc[d];
            we_cnt[d]++;
         end
         prev_clk[d] = srclk_m[d];
         prev_ld[d]  = loadn_m[d];
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_write(input int d);
      int start;
      int n;
      start = we_cnt[d];
      n = 0;
      while (we_cnt[d] == start && n < 200) begin
         tick(1);
         n++;
      end
      check("write_seen", 64'(we_cnt[d] - start), 64'd1);
   endtask

   // Compare the last recorded write against the parallel word and timing rules.
   task automatic check_scan(input int d, input logic [63:0] par);
      int bits, div, base;
      bits = (d == 0) ? BITS_A : BITS_B;
      div  = (d == 0) ? DIV_A  : DIV_B;
      base = (d == 0) ? BASE_A : BASE_B;
      check("din",      w_din[d],          par);
      check("sample",   w_sample[d],       par);
      check("addr",     w_addr[d],         64'(base));
      check("clk_edges", 64'(w_edges[d]),  64'(bits - 1));
      check("load_len", 64'(w_len[d]),     64'(div));
      check("latency",  64'(w_lat[d]),    64'(2 * bits * div));
   endtask

   task automatic pulse_scan(input int d, input logic [63:0] par);
      if (d == 0) begin par_a = par[7:0];  en_a = 1'b1; end
      else        begin par_b = par[15:0]; en_b = 1'b1; end
      tick(1);
      en_a = 1'b0;
      en_b = 1'b0;
      wait_write(d);
      check_scan(d, par);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int lc;
      int wc;
      logic [63:0] p;
      rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
      tick(3);
      check("rst_srclk_a", 64'(srclk_a), 64'd0);
      check("rst_loadn_a", 64'(loadn_a), 64'd1);
      check("rst_we_a",    64'(we_a),    64'd0);
      check("rst_busy_a",  64'(busy_a),  64'd0);
      check("rst_din_a",   din_a,        64'd0);
      check("rst_addr_a",  64'(addr_a),  64'd0);
      check("rst_smp_a",   64'(sample_a), 64'd0);
      check("rst_srclk_b", 64'(srclk_b), 64'd0);
      check("rst_loadn_b", 64'(loadn_b), 64'd1);
      check("rst_busy_b",  64'(busy_b),  64'd0);
      check("rst_valid_b", 64'(valid_b), 64'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick(2);

      // Single pulse, one chip, known pattern.
      pulse_scan(0, 64'hA5);
      tick(1);
      check("valid_one_cycle", 64'(valid_a), 64'd0);
      check("we_one_cycle",    64'(we_a),    64'd0);
      check("hold_din",        din_a,        64'hA5);
      tick(3);
      check("idle_busy", 64'(busy_a), 64'd0);

      // Two-chip chain: chip nearest the reader holds the upper byte.
      pulse_scan(1, 64'h8001);
      tick(10);
      check("b_idle_busy", 64'(busy_b), 64'd0);

      for (int i = 0; i < 5; i++) begin
         p = 64'($urandom_range(0, 255));
         pulse_scan(0, p);
         tick($urandom_range(1, 4));
      end
      for (int i = 0; i < 4; i++) begin
         p = 64'($urandom_range(0, 65535));
         pulse_scan(1, p);
         tick(10);
      end

      // Continuous scanning on A: back-to-back period and data change.
      par_a = 8'h00;
      en_a = 1'b1;
      wait_write(0);
      check_scan(0, 64'h00);
      par_a = 8'hFF;
      wait_write(0);
      en_a = 1'b0;
      check_scan(0, 64'hFF);
      check("period_a", 64'(interval[0]), 64'(2 * BITS_A * DIV_A + 2));
      lc = load_cnt[0];
      tick(20);
      check("a_stops", 64'(load_cnt[0] - lc), 64'd0);

      // Enable dropped during the second SHIFT_LOW: scan still completes once.
      par_a = 8'h3C;
      en_a = 1'b1;
      tick(7);
      en_a = 1'b0;
      check("drop_busy", 64'(busy_a), 64'd1);
      wait_write(0);
      check_scan(0, 64'h3C);
      lc = load_cnt[0];
      wc = we_cnt[0];
      tick(60);
      check("drop_no_load", 64'(load_cnt[0] - lc), 64'd0);
      check("drop_no_we",   64'(we_cnt[0] - wc),   64'd0);
      check("drop_busy0",   64'(busy_a),           64'd0);

      // Reset during the fourth SHIFT_HIGH discards the partial sample.
      par_a = 8'h5A;
      en_a = 1'b1;
      tick(1);
      en_a = 1'b0;
      n = 0;
      while (!(edges[0] == 4 && srclk_a === 1'b1) && n < 100) begin
         tick(1);
         n++;
      end
      check("reach_sh4", 64'(edges[0]), 64'd4);
      wc = we_cnt[0];
      rst_a = 1'b1;
      tick(1);
      rst_a = 1'b0;
      check("mid_rst_srclk", 64'(srclk_a),  64'd0);
      check("mid_rst_loadn", 64'(loadn_a),  64'd1);
      check("mid_rst_busy",  64'(busy_a),   64'd0);
      check("mid_rst_smp",   64'(sample_a), 64'd0);
      check("mid_rst_din",   din_a,         64'd0);
      tick(60);
      check("mid_rst_no_we", 64'(we_cnt[0] - wc), 64'd0);
      pulse_scan(0, 64'hC3);

      // Continuous scanning on B with a 5-cycle gap.
      par_b = 16'h1234;
      en_b = 1'b1;
      wait_write(1);
      check_scan(1, 64'h1234);
      par_b = 16'hBEEF;
      for (int i = 0; i < GAP_B; i++) begin
         tick(1);
         check("gap_busy", 64'(busy_b), 64'd1);
         check("gap_loadn", 64'(loadn_b), 64'd1);
      end
      tick(1);
      check("gap_idle_busy",  64'(busy_b),  64'd0);
      check("gap_idle_loadn", 64'(loadn_b), 64'd1);
      tick(1);
      check("gap_then_load", 64'(loadn_b), 64'd0);
      en_b = 1'b0;
      wait_write(1);
      check_scan(1, 64'hBEEF);
      check("period_b", 64'(interval[1]), 64'(2 * BITS_B * DIV_B + 2 + GAP_B));
      tick(GAP_B + 3);
      check("b_end_busy", 64'(busy_b), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sn74hc165_reader.md
SN74HC165_READER -- requirements
Module: sn74hc165_reader

Interface
REQ-001 SHALL have parameter NUM_CHIPS, default 1, number of daisy-chained SN74HC165 devices; BITS = 8*NUM_CHIPS.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per shift-register clock half-period and per load pulse; legal range 1..255.
REQ-003 SHALL have parameter SCAN_GAP, default 0, idle clk cycles inserted after each completed scan.
REQ-004 SHALL have parameter ITEM_SIZE, default 64, width of the BRAM data word; BITS <= ITEM_SIZE.
REQ-005 SHALL have parameter DEPTH, default 1024, number of BRAM entries.
REQ-006 SHALL have parameter BASE_ADDR, default 0, BRAM word address the sample is written to.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  reset; one clock, synchronous, active-high.
REQ-009 enable  input  1  level; 1 = scan continuously.
REQ-010 sr_qh  input  1  serial data from QH of the last device in the chain.
REQ-011 sr_clk  output  1  shift clock to CLK of all devices.
REQ-012 sr_load_n  output  1  SH/LD to all devices; 0 = parallel load.
REQ-013 port_c_addr  output  $clog2(DEPTH)+1  BRAM write address.
REQ-014 port_c_din  output  ITEM_SIZE  BRAM write data.
REQ-015 port_c_we  output  1  BRAM write enable.
REQ-016 sample_data  output  BITS  last completed sample.
REQ-017 sample_valid  output  1  one-cycle pulse: sample_data updated.
REQ-018 busy  output  1  1 in any state other than IDLE.

Function
REQ-019 All outputs SHALL be registered; states: IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, WRITE, GAP.
REQ-020 IDLE: sr_clk=0, sr_load_n=1; if enable=1 at clock edge t, LOAD SHALL be entered and visible at t+1.
REQ-021 LOAD SHALL hold sr_load_n=0, sr_clk=0 for exactly CLK_DIV cycles, then enter SHIFT_LOW.
REQ-022 SHIFT_LOW SHALL hold sr_load_n=1, sr_clk=0 for CLK_DIV cycles; on its last cycle sr_qh SHALL be sampled into shift register as data <= {data[BITS-2:0], sr_qh}.
REQ-023 After a sample, if fewer than BITS bits are collected, SHIFT_HIGH SHALL follow (sr_clk=1 for CLK_DIV cycles) then SHIFT_LOW; after the BITS-th sample, WRITE SHALL follow.
REQ-024 A scan SHALL issue exactly BITS-1 sr_clk rising edges and one load pulse; first sampled bit lands in sample_data[BITS-1] (H input of device nearest the reader).
REQ-025 Scan duration from first LOAD cycle to WRITE SHALL be CLK_DIV*(2*BITS) cycles; WRITE lasts 1 cycle.
REQ-026 WRITE: port_c_we=1, port_c_addr=BASE_ADDR, port_c_din = data zero-extended to ITEM_SIZE, sample_data updated, sample_valid=1, all in the same cycle.
REQ-027 port_c_we SHALL be 0 in every state except WRITE; port_c_addr/port_c_din hold their last values otherwise.
REQ-028 After WRITE: if SCAN_GAP=0 go directly to IDLE; else GAP for exactly SCAN_GAP cycles then IDLE.
REQ-029 enable deasserted mid-scan SHALL NOT abort; scan completes including WRITE; then IDLE stays idle.
REQ-030 With enable held at 1 and SCAN_GAP=0, successive LOAD entries SHALL be 2*BITS*CLK_DIV+2 cycles apart.
REQ-031 Divider and bit counters SHALL not wrap or overflow for any legal parameter; bit counter width $clog2(BITS)+1.

Reset
REQ-032 rst=1 SHALL force, at the next edge and regardless of state (including mid-scan): state IDLE, sr_clk=0, sr_load_n=1, port_c_we=0, port_c_addr=0, port_c_din=0, sample_data=0, sample_valid=0, busy=0, all counters 0.
REQ-033 A partially collected sample SHALL be discarded on reset; no BRAM write occurs.

Verification
REQ-034 NUM_CHIPS=1, CLK_DIV=2, model drives parallel 8'hA5, enable pulsed 1 cycle -> sr_load_n low 2 cycles, 7 sr_clk rising edges, WRITE 32 cycles after LOAD start, port_c_din=64'h00000000000000A5, sample_valid one cycle.
REQ-035 NUM_CHIPS=2, CLK_DIV=1, parallel 16'h8001 (chip0=8'h80, chip1=8'h01, chip0 nearest) -> sample_data=16'h8001, 15 sr_clk edges, single port_c_we pulse at BASE_ADDR.
REQ-036 enable held 1, SCAN_GAP=0, CLK_DIV=2, BITS=8 -> LOAD starts every 34 cycles; inputs changed 8'h00->8'hFF between scans -> consecutive writes 0x00 then 0xFF.
REQ-037 rst asserted in SHIFT_HIGH of bit 4 -> next cycle sr_clk=0, sr_load_n=1, busy=0, no port_c_we for rest of test unless enable re-asserted.
REQ-038 enable dropped during SHIFT_LOW of bit 2 -> scan completes, one write, then busy=0 and no further LOAD.
REQ-039 SCAN_GAP=5, enable held 1 -> busy stays 1 for 5 GAP cycles after WRITE, then one IDLE cycle, then LOAD.
